// File: rtl/pip_reg_skid_if.sv
// Handshake bundle for the elastic pipeline stage register.
// The master side drives entries in; the slave side is the stage itself.
interface pip_reg_skid_if #(
   parameter int CTRL_WIDTH = 8,
   parameter int DATA_WIDTH = 96
);
   logic                  flush_i;
   logic                  valid_i;
   logic                  ready_o;
   logic [CTRL_WIDTH-1:0] ctrl_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [CTRL_WIDTH-1:0] ctrl_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic [1:0]            occupancy_o;

   modport master (
      output flush_i, valid_i, ctrl_i, data_i, ready_i,
      input  ready_o, valid_o, ctrl_o, data_o, occupancy_o
   );

   modport slave (
      input  flush_i, valid_i, ctrl_i, data_i, ready_i,
      output ready_o, valid_o, ctrl_o, data_o, occupancy_o
   );
endinterface

// File: rtl/pip_reg_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer and flush.
// Control is zeroed on bubbles so an empty slot never asserts side effects.
module pip_reg_skid #(
   parameter int CTRL_WIDTH = 8,
   parameter int DATA_WIDTH = 96
) (
   input  logic              clk_i,
   input  logic              rst_i,
   pip_reg_skid_if.slave     bus
);
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CTRL_WIDTH-1:0] r_main_ctrl;
   logic [CTRL_WIDTH-1:0] w_main_ctrl_nxt;
   logic [DATA_WIDTH-1:0] r_main_data;
   logic [DATA_WIDTH-1:0] w_main_data_nxt;
   logic [CTRL_WIDTH-1:0] r_skid_ctrl;
   logic [CTRL_WIDTH-1:0] w_skid_ctrl_nxt;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic [DATA_WIDTH-1:0] w_skid_data_nxt;

   logic w_ready;
   logic w_valid;
   logic w_acc_in;
   logic w_acc_out;

   // ready depends on state only, so no ready_i -> ready_o path exists
   assign w_ready   = (r_state != S_TWO);
   assign w_valid   = (r_state != S_EMPTY);
   assign w_acc_in  = bus.valid_i & w_ready;
   assign w_acc_out = w_valid & bus.ready_i;

   assign bus.ready_o     = w_ready;
   assign bus.valid_o     = w_valid;
   assign bus.ctrl_o      = w_valid ? r_main_ctrl : '0;
   assign bus.data_o      = r_main_data;
   assign bus.occupancy_o = r_state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_EMPTY;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_main_ctrl <= w_main_ctrl_nxt;
         r_main_data <= w_main_data_nxt;
         r_skid_ctrl <= w_skid_ctrl_nxt;
         r_skid_data <= w_skid_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_main_ctrl_nxt = r_main_ctrl;
      w_main_data_nxt = r_main_data;
      w_skid_ctrl_nxt = r_skid_ctrl;
      w_skid_data_nxt = r_skid_data;
      if (bus.flush_i) begin
         // payload is kept so data_o holds its last value
         w_state_nxt     = S_EMPTY;
         w_main_ctrl_nxt = '0;
         w_skid_ctrl_nxt = '0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_acc_in) begin
                  w_main_ctrl_nxt = bus.ctrl_i;
                  w_main_data_nxt = bus.data_i;
                  w_state_nxt     = S_ONE;
               end
            end
            S_ONE: begin
               if (w_acc_in && w_acc_out) begin
                  w_main_ctrl_nxt = bus.ctrl_i;
                  w_main_data_nxt = bus.data_i;
               end else if (w_acc_in) begin
                  w_skid_ctrl_nxt = bus.ctrl_i;
                  w_skid_data_nxt = bus.data_i;
                  w_state_nxt     = S_TWO;
               end else if (w_acc_out) begin
                  w_main_ctrl_nxt = '0;
                  w_state_nxt     = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_acc_out) begin
                  w_main_ctrl_nxt = r_skid_ctrl;
                  w_main_data_nxt = r_skid_data;
                  w_skid_ctrl_nxt = '0;
                  w_state_nxt     = S_ONE;
               end
            end
            default: begin
               w_state_nxt     = S_EMPTY;
               w_main_ctrl_nxt = '0;
               w_skid_ctrl_nxt = '0;
            end
         endcase
      end
   end
endmodule
